// File: rtl/stream_demux_qos.sv
// Routes one merged QoS-tagged stream to STREAM_COUNT output streams via a single registered slot.
// Optional macro STREAM_DEMUX_DROP_INVALID_EN discards packets whose first-beat ID is out of range.
module stream_demux_qos #(
    parameter int DATA_WIDTH   = 32,
    parameter int QOS_WIDTH    = 4,
    parameter int STREAM_COUNT = 2,
    parameter int ID_WIDTH     = $clog2(STREAM_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic [ID_WIDTH-1:0]     s_id_i,
    input  logic [QOS_WIDTH-1:0]    s_qos_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [DATA_WIDTH-1:0]   m_data_o [STREAM_COUNT],
    output logic [QOS_WIDTH-1:0]    m_qos_o  [STREAM_COUNT],
    output logic [STREAM_COUNT-1:0] m_last_o,
    output logic [STREAM_COUNT-1:0] m_valid_o,
    input  logic [STREAM_COUNT-1:0] m_ready_i,
    output logic                    drop_o
);

    // Valid/ready: a beat moves when valid and ready are both high at a rising clk;
    // valid never depends combinationally on ready, and a raised valid holds its beat until taken.
    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    state_t              state, state_n;
    logic [ID_WIDTH-1:0] lock_id;
    logic [ID_WIDTH-1:0] slot_id;
    logic                slot_valid;
    logic [ID_WIDTH-1:0] dest_id;
    logic                id_in_range;
    logic                first_beat;
    logic                drain;
    logic                accept;
    logic                write;
    logic                drop_beat;

    always_comb begin
        first_beat  = (state == IDLE);
        id_in_range = ({1'b0, s_id_i} < (ID_WIDTH + 1)'(STREAM_COUNT));
        dest_id     = first_beat ? (id_in_range ? s_id_i : '0) : lock_id;
        drain       = slot_valid && m_ready_i[slot_id];
`ifdef STREAM_DEMUX_DROP_INVALID_EN
        drop_beat   = (state == DROP) || (first_beat && !id_in_range);
        s_ready_o   = !rst && ((state == DROP) || !slot_valid || drain);
`else
        drop_beat   = 1'b0;
        s_ready_o   = !rst && (!slot_valid || drain);
`endif
        accept      = s_valid_i && s_ready_o;
        write       = accept && !drop_beat;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept && !s_last_i) state_n = drop_beat ? DROP : PKT;
            PKT:  if (accept && s_last_i)  state_n = IDLE;
            DROP: if (accept && s_last_i)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lock_id    <= '0;
            slot_valid <= 1'b0;
            slot_id    <= '0;
            m_last_o   <= '0;
            for (int k = 0; k < STREAM_COUNT; k++) begin
                m_data_o[k] <= '0;
                m_qos_o[k]  <= '0;
            end
        end else begin
            state <= state_n;
            if (accept && first_beat) lock_id <= dest_id;
            if (write) begin
                slot_valid <= 1'b1;
                slot_id    <= dest_id;
                // Only the destination's registers change; other streams keep their last beat.
                for (int k = 0; k < STREAM_COUNT; k++) begin
                    if (dest_id == ID_WIDTH'(k)) begin
                        m_data_o[k] <= s_data_i;
                        m_qos_o[k]  <= s_qos_i;
                        m_last_o[k] <= s_last_i;
                    end
                end
            end else if (drain) begin
                slot_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < STREAM_COUNT; k++)
            m_valid_o[k] = slot_valid && (slot_id == ID_WIDTH'(k));
    end

`ifdef STREAM_DEMUX_DROP_INVALID_EN
    logic drop_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= 1'b0;
        else     drop_q <= accept && drop_beat && s_last_i;
    end
    assign drop_o = drop_q;
`else
    assign drop_o = 1'b0;
`endif

endmodule
